// File: rtl/pulse_scheduler.sv
// Two-requester round-robin front end for one delayed pulse-train generator.
// A grant latches delay/count, waits, then emits fixed-width pulses and reports done.
module pulse_scheduler #(
  parameter int DELAY_W  = 8,
  parameter int CNT_W    = 4,
  parameter int HIGH_CYC = 2,
  parameter int LOW_CYC  = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         req,
  input  logic [DELAY_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0]   cfg_count,
  input  logic               abort,
  output logic [1:0]         grant,
  output logic               owner,
  output logic               busy,
  output logic               signal,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, WAIT, HIGH, LOW} state_t;

  localparam int PH_MAX = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0] HI_LOAD = PH_W'(HIGH_CYC - 1);
  localparam logic [PH_W-1:0] LO_LOAD = PH_W'(LOW_CYC - 1);

  state_t             state_q, state_d;
  logic [DELAY_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0]   pcnt_q, pcnt_d;
  logic [PH_W-1:0]    ph_q, ph_d;     // HIGH and LOW phases never overlap, so they share one counter
  logic [1:0]         grant_q, grant_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d; // arbitration pointer: index of last winner
  logic               busy_q, busy_d;
  logic               signal_q, signal_d;
  logic               done_q, done_d;
  logic               win;

  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    pcnt_d   = pcnt_q;
    ph_d     = ph_q;
    grant_d  = 2'b00;
    owner_d  = owner_q;
    last_d   = last_q;
    busy_d   = busy_q;
    signal_d = signal_q;
    done_d   = 1'b0;
    win      = (req == 2'b11) ? ~last_q : req[1];

    if (abort && state_q != IDLE) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      signal_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          busy_d   = 1'b0;
          signal_d = 1'b0;
          if (req != 2'b00) begin
            state_d = WAIT;
            grant_d = {win, ~win};
            owner_d = win;
            last_d  = win;
            busy_d  = 1'b1;
            dcnt_d  = cfg_delay;
            pcnt_d  = cfg_count;
          end
        end
        WAIT: begin
          if (dcnt_q != '0) begin
            dcnt_d = dcnt_q - 1'b1;
          end else if (pcnt_q != '0) begin
            state_d  = HIGH;
            signal_d = 1'b1;
            ph_d     = HI_LOAD;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
        HIGH: begin
          if (ph_q != '0) begin
            ph_d = ph_q - 1'b1;
          end else begin
            pcnt_d   = pcnt_q - 1'b1;
            signal_d = 1'b0;
            // final falling edge doubles as completion; no trailing low gap
            if (pcnt_q == CNT_W'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d = LOW;
              ph_d    = LO_LOAD;
            end
          end
        end
        LOW: begin
          if (ph_q != '0) begin
            ph_d = ph_q - 1'b1;
          end else begin
            state_d  = HIGH;
            signal_d = 1'b1;
            ph_d     = HI_LOAD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      dcnt_q   <= '0;
      pcnt_q   <= '0;
      ph_q     <= '0;
      grant_q  <= 2'b00;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;  // requester 0 wins the first tie
      busy_q   <= 1'b0;
      signal_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      pcnt_q   <= pcnt_d;
      ph_q     <= ph_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      signal_q <= signal_d;
      done_q   <= done_d;
    end
  end

  assign grant  = grant_q;
  assign owner  = owner_q;
  assign busy   = busy_q;
  assign signal = signal_q;
  assign done   = done_q;

endmodule
